// File: rtl/pkt_filter_pkg.sv
// Shared types and default constants for the packet filter ingress path.
// Buffer elements are laid out as {eop, data}, so the eop flag sits at bit W_DATA.
package pkt_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    REWIND,
    DISCARD
  } ingress_state_t;

  localparam int DEF_W_DATA        = 16;
  localparam int DEF_MAX_PKT_WORDS = 759;
  localparam int EOP_BIT           = DEF_W_DATA;

endpackage

// File: rtl/pkt_ingress_writer.sv
// Write side of the packet buffer: writes sop/eop framed beats, commits good packets,
// and rewinds the FIFO write pointer over dropped, truncated or oversize packets.
module pkt_ingress_writer
  import pkt_filter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 11,
  parameter int W_DATA        = DEF_W_DATA,
  parameter int MAX_PKT_WORDS = DEF_MAX_PKT_WORDS,
  parameter int W_CNT         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_drop,
  input  logic [W_DATA-1:0]     in_data,
  output logic [W_DATA:0]       fifo_wdata,
  output logic                  fifo_wen,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH:0]   fifo_wptr,
  output logic                  fifo_wrst,
  output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
  output logic [ADDR_WIDTH:0]   commit_wptr,
  output logic                  pkt_committed,
  output logic                  pkt_dropped,
  output logic [W_CNT-1:0]      commit_count,
  output logic [W_CNT-1:0]      drop_count,
  output logic [W_CNT-1:0]      orphan_count
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_BEATS = ADDR_WIDTH'(MAX_PKT_WORDS);

  ingress_state_t state, state_nxt;
  logic [PW-1:0]         start_ptr;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic                  oversize, oversize_nxt;
  logic                  accept, start_pkt, beat_inc, commit, orphan;

  assign fifo_wdata    = {in_eop, in_data};
  assign fifo_wrst     = (state == REWIND);
  assign pkt_dropped   = (state == REWIND);
  assign fifo_rst_wptr = start_ptr;
  assign accept        = in_valid && in_ready;

  // A sop seen mid-packet is held off so the truncated packet can be rewound first.
  always_comb begin
    case (state)
      IDLE:    in_ready = !fifo_full;
      PKT:     in_ready = !fifo_full && !in_sop;
      DISCARD: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    oversize_nxt = oversize;
    fifo_wen     = 1'b0;
    start_pkt    = 1'b0;
    beat_inc     = 1'b0;
    commit       = 1'b0;
    orphan       = 1'b0;
    case (state)
      IDLE: begin
        if (accept && in_sop) begin
          fifo_wen  = 1'b1;
          start_pkt = 1'b1;
          if (in_eop && !in_drop) begin
            commit = 1'b1;
          end else if (in_eop) begin
            state_nxt    = REWIND;
            oversize_nxt = 1'b0;
          end else begin
            state_nxt = PKT;
          end
        end else if (accept) begin
          orphan = 1'b1;
        end
      end
      PKT: begin
        if (in_valid && in_sop) begin
          state_nxt    = REWIND;
          oversize_nxt = 1'b0;
        end else if (accept && in_eop) begin
          if (!in_drop) begin
            fifo_wen  = 1'b1;
            commit    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt    = REWIND;
            oversize_nxt = 1'b0;
          end
        end else if (accept) begin
          if (beat_cnt == MAX_BEATS) begin
            state_nxt    = REWIND;
            oversize_nxt = 1'b1;
          end else begin
            fifo_wen = 1'b1;
            beat_inc = 1'b1;
          end
        end
      end
      REWIND: begin
        state_nxt = oversize ? DISCARD : IDLE;
      end
      DISCARD: begin
        if (accept && in_eop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      oversize <= 1'b0;
    end else begin
      state    <= state_nxt;
      oversize <= oversize_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_ptr     <= '0;
      beat_cnt      <= '0;
      commit_wptr   <= '0;
      pkt_committed <= 1'b0;
      commit_count  <= '0;
      drop_count    <= '0;
      orphan_count  <= '0;
    end else begin
      pkt_committed <= commit;
      if (start_pkt) begin
        start_ptr <= fifo_wptr;
        beat_cnt  <= ADDR_WIDTH'(1);
      end else if (beat_inc) begin
        beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
      end
      // The final beat is written this cycle, so the committed end is one past it.
      if (commit) begin
        commit_wptr  <= fifo_wptr + PW'(1);
        commit_count <= commit_count + W_CNT'(1);
      end
      if (state == REWIND) begin
        drop_count <= drop_count + W_CNT'(1);
      end
      if (orphan) begin
        orphan_count <= orphan_count + W_CNT'(1);
      end
    end
  end

endmodule
